// File: rtl/clock_mode_ctrl.sv
// Mode/setup controller for the HMS clock: debounced buttons, CLOCK/SET state
// machine, one-clk increment enables for the counters and the set-field blink mask.
module clock_mode_ctrl #(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned DEB_DIV   = 500_000,
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw0,
   input  logic       i_sw1,
   input  logic       i_sw2,
   input  logic       i_sec_wrap,
   input  logic       i_min_wrap,
   output logic [1:0] o_mode,
   output logic       o_sec_inc,
   output logic       o_min_inc,
   output logic       o_hour_inc,
   output logic [5:0] o_blink_mask
);

   typedef enum logic [1:0] {
      CLOCK    = 2'd0,
      SET_SEC  = 2'd1,
      SET_MIN  = 2'd2,
      SET_HOUR = 2'd3
   } state_t;

   state_t      state_reg, state_next;

   logic [2:0]  sync1_reg, sync2_reg, samp_reg, deb_reg, press_reg;
   logic [2:0]  deb_next, press_next, pressed_smp, released_smp;
   logic [31:0] deb_cnt_reg, deb_cnt_next;
   logic        samp_stb;

   logic [31:0] tick_cnt_reg, tick_cnt_next;
   logic [31:0] blink_cnt_reg, blink_cnt_next;
   logic        blink_phase_reg, blink_phase_next;
   logic        sec_inc_reg, min_inc_reg, hour_inc_reg;
   logic        sec_inc_next, min_inc_next, hour_inc_next;

   logic        ev_mode, ev_pos, field_press, stay_clock, tick_done;

   // Debounce: two agreeing samples are needed to change the settled level.
   always_comb begin
      samp_stb     = (deb_cnt_reg == 32'(DEB_DIV - 1));
      deb_cnt_next = samp_stb ? 32'd0 : deb_cnt_reg + 32'd1;
      pressed_smp  = ~sync2_reg & ~samp_reg;
      released_smp = sync2_reg & samp_reg;
      deb_next     = deb_reg;
      press_next   = 3'b000;
      if (samp_stb) begin
         deb_next   = (deb_reg & ~pressed_smp) | released_smp;
         press_next = deb_reg & pressed_smp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= 3'b111;
         sync2_reg   <= 3'b111;
         samp_reg    <= 3'b111;
         deb_reg     <= 3'b111;
         press_reg   <= 3'b000;
         deb_cnt_reg <= 32'd0;
      end else begin
         sync1_reg   <= {i_sw2, i_sw1, i_sw0};
         sync2_reg   <= sync1_reg;
         if (samp_stb) samp_reg <= sync2_reg;
         deb_reg     <= deb_next;
         press_reg   <= press_next;
         deb_cnt_reg <= deb_cnt_next;
      end
   end

   // Events resolve sw0 > sw1 > sw2; a lower-priority event in the same cycle is lost.
   always_comb begin
      ev_mode     = press_reg[0];
      ev_pos      = press_reg[1] & ~press_reg[0];
      field_press = press_reg[2] & ~press_reg[1] & ~press_reg[0];
      state_next  = state_reg;
      case (state_reg)
         CLOCK:    if (ev_mode) state_next = SET_SEC;
         SET_SEC:  if (ev_mode) state_next = CLOCK; else if (ev_pos) state_next = SET_MIN;
         SET_MIN:  if (ev_mode) state_next = CLOCK; else if (ev_pos) state_next = SET_HOUR;
         SET_HOUR: if (ev_mode) state_next = CLOCK; else if (ev_pos) state_next = SET_SEC;
         default:  state_next = CLOCK;
      endcase
   end

   // Carries and ticks only count while CLOCK is both the current and next state,
   // so nothing leaks out on the edge that enters a SET mode.
   always_comb begin
      stay_clock    = (state_reg == CLOCK) && (state_next == CLOCK);
      tick_done     = (tick_cnt_reg == 32'(TICK_DIV - 1));
      tick_cnt_next = 32'd0;
      if (stay_clock && !tick_done) tick_cnt_next = tick_cnt_reg + 32'd1;
      sec_inc_next  = (stay_clock && tick_done) || ((state_reg == SET_SEC) && field_press);
      min_inc_next  = (stay_clock && i_sec_wrap) || ((state_reg == SET_MIN) && field_press);
      hour_inc_next = (stay_clock && i_min_wrap) || ((state_reg == SET_HOUR) && field_press);
   end

   // Blink restarts visible on every state change so a new field shows immediately.
   always_comb begin
      blink_cnt_next   = blink_cnt_reg + 32'd1;
      blink_phase_next = blink_phase_reg;
      if (state_next != state_reg) begin
         blink_cnt_next   = 32'd0;
         blink_phase_next = 1'b0;
      end else if (blink_cnt_reg == 32'(BLINK_DIV - 1)) begin
         blink_cnt_next   = 32'd0;
         blink_phase_next = ~blink_phase_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= CLOCK;
         tick_cnt_reg    <= 32'd0;
         blink_cnt_reg   <= 32'd0;
         blink_phase_reg <= 1'b0;
         sec_inc_reg     <= 1'b0;
         min_inc_reg     <= 1'b0;
         hour_inc_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         tick_cnt_reg    <= tick_cnt_next;
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         sec_inc_reg     <= sec_inc_next;
         min_inc_reg     <= min_inc_next;
         hour_inc_reg    <= hour_inc_next;
      end
   end

   always_comb begin
      o_blink_mask = 6'b000000;
      case (state_reg)
         SET_SEC:  o_blink_mask = {4'b0000, {2{blink_phase_reg}}};
         SET_MIN:  o_blink_mask = {2'b00, {2{blink_phase_reg}}, 2'b00};
         SET_HOUR: o_blink_mask = {{2{blink_phase_reg}}, 4'b0000};
         default:  o_blink_mask = 6'b000000;
      endcase
   end

   assign o_mode     = state_reg;
   assign o_sec_inc  = sec_inc_reg;
   assign o_min_inc  = min_inc_reg;
   assign o_hour_inc = hour_inc_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed vector table, hand-written reset/carry
// sequences and random button/wrap operations against an abstract mode model.
module tb_clock_mode_ctrl;

   localparam int TICK  = 10;
   localparam int BLINK = 4;
   localparam int WIN   = 24;

   localparam int OP_SW0 = 0, OP_SW1 = 1, OP_SW2 = 2, OP_SWRAP = 3,
                  OP_MWRAP = 4, OP_GLITCH = 5, OP_SW0_SW2 = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_sw0 = 1'b1, i_sw1 = 1'b1, i_sw2 = 1'b1;
   logic       i_sec_wrap = 1'b0, i_min_wrap = 1'b0;
   logic [1:0] o_mode;
   logic       o_sec_inc, o_min_inc, o_hour_inc;
   logic [5:0] o_blink_mask;

   clock_mode_ctrl #(.TICK_DIV(10), .DEB_DIV(2), .BLINK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_sw0(i_sw0), .i_sw1(i_sw1), .i_sw2(i_sw2),
      .i_sec_wrap(i_sec_wrap), .i_min_wrap(i_min_wrap),
      .o_mode(o_mode), .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc),
      .o_hour_inc(o_hour_inc), .o_blink_mask(o_blink_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         op;
      logic [1:0] mode;
      int         n_sec;
      int         n_min;
      int         n_hour;
      bit         chk_sec;
   } vec_t;

   vec_t       tbl[17];
   int         checks = 0, errors = 0;
   int         since = 0;
   logic [1:0] prev_mode = 2'd0;
   int         sec_cnt = 0, min_cnt = 0, hour_cnt = 0;
   int         model_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock; outputs judged 1 ns after the edge from time since the last mode change.
   task automatic step();
      logic       sw_w, mn_w;
      int         m;
      logic [5:0] field;
      logic [2:0] incs, allow;
      sw_w = i_sec_wrap;
      mn_w = i_min_wrap;
      @(posedge clk);
      #1;
      since++;
      if (o_mode !== prev_mode) since = 0;
      prev_mode = o_mode;
      if (o_sec_inc)  sec_cnt++;
      if (o_min_inc)  min_cnt++;
      if (o_hour_inc) hour_cnt++;
      m = int'(o_mode);
      if (m == 0) begin
         check("clock_tick", 32'(o_sec_inc), 32'(since > 0 && since % TICK == 0));
         check("min_carry", 32'(o_min_inc), 32'(since > 0 && sw_w));
         check("hour_carry", 32'(o_hour_inc), 32'(since > 0 && mn_w));
         check("clock_mask", 32'(o_blink_mask), 32'd0);
      end else begin
         field = 6'(3 << (2 * (m - 1)));
         check("blink_mask", 32'(o_blink_mask), ((since / BLINK) % 2 == 1) ? 32'(field) : 32'd0);
         incs  = {o_hour_inc, o_min_inc, o_sec_inc};
         allow = 3'(1 << (m - 1));
         check("set_inc_field", 32'(incs & ~allow), 32'd0);
      end
   endtask

   function automatic string op_name(input int op);
      case (op)
         OP_SW0:    return "press_sw0";
         OP_SW1:    return "press_sw1";
         OP_SW2:    return "press_sw2";
         OP_SWRAP:  return "sec_wrap";
         OP_MWRAP:  return "min_wrap";
         OP_GLITCH: return "glitch_sw2";
         default:   return "press_sw0_sw2";
      endcase
   endfunction

   // Each operation occupies a fixed window so debounce always settles before the next.
   task automatic run_op(input int op, output int ds, output int dm, output int dh);
      int s0, m0, h0;
      s0 = sec_cnt; m0 = min_cnt; h0 = hour_cnt;
      case (op)
         OP_SWRAP, OP_MWRAP: begin
            repeat (6) step();
            if (op == OP_SWRAP) i_sec_wrap = 1'b1; else i_min_wrap = 1'b1;
            step();
            i_sec_wrap = 1'b0;
            i_min_wrap = 1'b0;
            repeat (WIN - 7) step();
         end
         OP_GLITCH: begin
            i_sw2 = 1'b0;
            step();
            i_sw2 = 1'b1;
            repeat (WIN - 1) step();
         end
         default: begin
            i_sw0 = !(op == OP_SW0 || op == OP_SW0_SW2);
            i_sw1 = !(op == OP_SW1);
            i_sw2 = !(op == OP_SW2 || op == OP_SW0_SW2);
            repeat (12) step();
            {i_sw2, i_sw1, i_sw0} = 3'b111;
            repeat (WIN - 12) step();
         end
      endcase
      ds = sec_cnt - s0; dm = min_cnt - m0; dh = hour_cnt - h0;
      $display("op %-13s mode=%0d inc sec/min/hour=%0d/%0d/%0d", op_name(op), o_mode, ds, dm, dh);
   endtask

   function automatic int model_next(input int mode, input int op);
      if (op == OP_SW0 || op == OP_SW0_SW2) return (mode == 0) ? 1 : 0;
      if (op == OP_SW1 && mode != 0) return (mode == 3) ? 1 : mode + 1;
      return mode;
   endfunction

   initial begin
      int ds, dm, dh, s0, op, bound;
      int e_sec, e_min, e_hour;

      tbl[0]  = '{OP_SW0,     2'd1, 0, 0, 0, 1'b0};
      tbl[1]  = '{OP_SW1,     2'd2, 0, 0, 0, 1'b1};
      tbl[2]  = '{OP_SW2,     2'd2, 0, 1, 0, 1'b1};
      tbl[3]  = '{OP_SW2,     2'd2, 0, 1, 0, 1'b1};
      tbl[4]  = '{OP_SW2,     2'd2, 0, 1, 0, 1'b1};
      tbl[5]  = '{OP_GLITCH,  2'd2, 0, 0, 0, 1'b1};
      tbl[6]  = '{OP_SWRAP,   2'd2, 0, 0, 0, 1'b1};
      tbl[7]  = '{OP_MWRAP,   2'd2, 0, 0, 0, 1'b1};
      tbl[8]  = '{OP_SW0_SW2, 2'd0, 0, 0, 0, 1'b0};
      tbl[9]  = '{OP_SW0,     2'd1, 0, 0, 0, 1'b0};
      tbl[10] = '{OP_SW2,     2'd1, 1, 0, 0, 1'b1};
      tbl[11] = '{OP_SW1,     2'd2, 0, 0, 0, 1'b1};
      tbl[12] = '{OP_SW1,     2'd3, 0, 0, 0, 1'b1};
      tbl[13] = '{OP_SW2,     2'd3, 0, 0, 1, 1'b1};
      tbl[14] = '{OP_SW1,     2'd1, 0, 0, 0, 1'b1};
      tbl[15] = '{OP_SW1,     2'd2, 0, 0, 0, 1'b1};
      tbl[16] = '{OP_SW1,     2'd3, 0, 0, 0, 1'b1};

      // Reset state, then free-running seconds ticks
      repeat (3) @(posedge clk);
      #1;
      check("reset_mode", 32'(o_mode), 32'd0);
      check("reset_mask", 32'(o_blink_mask), 32'd0);
      check("reset_inc", 32'({o_sec_inc, o_min_inc, o_hour_inc}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      since = 0; prev_mode = 2'd0;
      s0 = sec_cnt;
      repeat (35) step();
      check("tick_count_35", 32'(sec_cnt - s0), 32'd3);
      $display("tick run: %0d sec pulses in 35 clks", sec_cnt - s0);

      // Carries in CLOCK mode land exactly one clock after the wrap pulse
      i_sec_wrap = 1'b1; step(); i_sec_wrap = 1'b0;
      check("sec_wrap_n1", 32'({o_min_inc, o_hour_inc}), 32'b10);
      step();
      check("sec_wrap_n2", 32'(o_min_inc), 32'd0);
      i_min_wrap = 1'b1; step(); i_min_wrap = 1'b0;
      check("min_wrap_n1", 32'({o_min_inc, o_hour_inc}), 32'b01);
      step();
      check("min_wrap_n2", 32'(o_hour_inc), 32'd0);
      $display("carry run: sec_wrap and min_wrap applied");

      foreach (tbl[i]) begin
         run_op(tbl[i].op, ds, dm, dh);
         check($sformatf("vec%0d_mode", i), 32'(o_mode), 32'(tbl[i].mode));
         if (tbl[i].chk_sec) check($sformatf("vec%0d_sec", i), 32'(ds), 32'(tbl[i].n_sec));
         check($sformatf("vec%0d_min", i), 32'(dm), 32'(tbl[i].n_min));
         check($sformatf("vec%0d_hour", i), 32'(dh), 32'(tbl[i].n_hour));
      end

      // Asynchronous reset while the hour field is blanked
      bound = 0;
      while (o_blink_mask == 6'b0 && bound < 20) begin
         step();
         bound++;
      end
      check("hour_blink_seen", 32'(o_blink_mask), 32'b110000);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mode", 32'(o_mode), 32'd0);
      check("async_rst_mask", 32'(o_blink_mask), 32'd0);
      check("async_rst_inc", 32'({o_sec_inc, o_min_inc, o_hour_inc}), 32'd0);
      $display("async reset: mode=%0d mask=%b", o_mode, o_blink_mask);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      since = 0; prev_mode = 2'd0; model_mode = 0;

      // Random operations against the abstract mode model
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 6));
         e_sec  = (model_mode == 1 && op == OP_SW2) ? 1 : 0;
         e_min  = ((model_mode == 2 && op == OP_SW2) || (model_mode == 0 && op == OP_SWRAP)) ? 1 : 0;
         e_hour = ((model_mode == 3 && op == OP_SW2) || (model_mode == 0 && op == OP_MWRAP)) ? 1 : 0;
         run_op(op, ds, dm, dh);
         if (model_mode != 0 && op != OP_SW0 && op != OP_SW0_SW2)
            check("rand_sec", 32'(ds), 32'(e_sec));
         check("rand_min", 32'(dm), 32'(e_min));
         check("rand_hour", 32'(dh), 32'(e_hour));
         model_mode = model_next(model_mode, op);
         check("rand_mode", 32'(o_mode), 32'(model_mode));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
